// File: rtl/greg_emeas.sv
// greg_emeas: period / high-time meter for an asynchronous pulse stream.
// One START arms one measurement; CTRL selects the timeout window.
module greg_emeas #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SIG,
  input  logic        START,
  input  logic [3:0]  CTRL,
  output logic [31:0] PCNT,
  output logic [31:0] HCNT,
  output logic        VALID,
  output logic        TMO,
  output logic        BUSY,
  output logic        SIGS
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  state_t state_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  logic [3:0]  ctrl_q;
  logic [31:0] tcnt_q;
  logic [31:0] prun_q;
  logic [31:0] hrun_q;
  logic [31:0] hcap_q;
  logic [31:0] pcnt_q;
  logic [31:0] hcnt_q;
  logic        valid_q;
  logic        tmo_q;
  logic        busy_q;

  logic        sig_s;
  logic        rise;
  logic        fall;
  logic [31:0] limit;
  logic        tmo_hit;
  logic [31:0] tcnt_d;
  logic [31:0] prun_d;
  logic [31:0] hrun_d;

  assign sig_s   = sync_q[SYNC_STAGES-1];
  assign rise    = sig_s & ~prev_q;
  assign fall    = ~sig_s & prev_q;
  assign limit   = (32'd1 << (5'd16 + {1'b0, ctrl_q})) - 32'd1;
  assign tmo_hit = (tcnt_q == limit);
  assign tcnt_d  = tcnt_q + 32'd1;
  assign prun_d  = prun_q + 32'd1;
  assign hrun_d  = hrun_q + 32'd1;

  // Synchronizer chain plus one extra flop for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Measurement FSM; timeout check takes priority over any edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      tcnt_q  <= '0;
      prun_q  <= '0;
      hrun_q  <= '0;
      hcap_q  <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
            ctrl_q  <= CTRL;
          end
        end
        ARM: begin
          if (tmo_hit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_d;
            if (rise) begin
              state_q <= HIGH;
              prun_q  <= 32'd1;
              hrun_q  <= 32'd1;
            end
          end
        end
        HIGH: begin
          if (tmo_hit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_d;
            prun_q <= prun_d;
            if (fall) begin
              state_q <= LOW;
              hcap_q  <= hrun_q;
            end else begin
              hrun_q <= hrun_d;
            end
          end
        end
        LOW: begin
          if (tmo_hit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else if (rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pcnt_q  <= prun_q;
            hcnt_q  <= hcap_q;
            valid_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_d;
            prun_q <= prun_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PCNT  = pcnt_q;
  assign HCNT  = hcnt_q;
  assign VALID = valid_q;
  assign TMO   = tmo_q;
  assign BUSY  = busy_q;
  assign SIGS  = sync_q[SYNC_STAGES-1];

endmodule

// File: doc/greg_emeas.md
GREG_EMEAS -- requirements
Module: greg_emeas

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on SIG (legal 2..4).
REQ-002 Port: CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: SIG  input  1  asynchronous pulse stream to measure (e.g. a divided clock or an LED tap from the counter block).
REQ-005 Port: START  input  1  one-cycle request to begin one measurement.
REQ-006 Port: CTRL  input  4  timeout select; limit = 2^(CTRL+16) CLK cycles.
REQ-007 Port: PCNT  output  32  measured period in CLK cycles, rising edge to rising edge.
REQ-008 Port: HCNT  output  32  measured high time in CLK cycles, rising edge to falling edge.
REQ-009 Port: VALID  output  1  one-cycle pulse when PCNT/HCNT update.
REQ-010 Port: TMO  output  1  sticky timeout flag.
REQ-011 Port: BUSY  output  1  high while a measurement is in progress.
REQ-012 Port: SIGS  output  1  synchronized SIG, for debug/LED.

Function
REQ-013 SIG shall pass through SYNC_STAGES flops, then one further flop for edge detection; rise = sync & ~prev, fall = ~sync & prev.
REQ-014 The FSM shall have states IDLE, ARM, HIGH, LOW.
REQ-015 IDLE: START -> ARM, clear TMO, clear the run counter; otherwise hold.
REQ-016 ARM: rise -> HIGH with both counters loaded to 1; a START while not in IDLE shall be ignored.
REQ-017 HIGH: increment both the period and high counters each cycle; fall -> LOW, capturing the high count.
REQ-018 LOW: increment the period counter; rise -> IDLE, load PCNT with the period count, load HCNT with the captured high count, pulse VALID.
REQ-019 For a SIG with period P and high time H (in CLK cycles, stable, synchronous), PCNT shall equal P and HCNT shall equal H.
REQ-020 VALID shall assert in the same cycle PCNT/HCNT change, exactly one cycle wide.
REQ-021 Timeout counter: runs in ARM, HIGH and LOW; on reaching 2^(CTRL+16)-1 the FSM shall go to IDLE, set TMO, leave PCNT/HCNT unchanged, and not pulse VALID.
REQ-022 CTRL shall be sampled on START and held for the measurement; CTRL changes mid-measurement shall have no effect.
REQ-023 A rise and timeout in the same cycle: timeout wins.
REQ-024 START in the same cycle as completion (LOW + rise): complete the current measurement; START shall be ignored.
REQ-025 SIG stuck high (no fall) or stuck low (no rise) shall terminate only via timeout.
REQ-026 BUSY = (state != IDLE), registered-equivalent; all outputs shall come directly from flip-flops.
REQ-027 Internal counters shall be 32 bits and never wrap; the timeout limit bounds them (max 2^31).

Reset
REQ-028 RST_N low shall asynchronously force state IDLE; PCNT=0, HCNT=0, VALID=0, TMO=0, BUSY=0, SIGS=0, and all synchronizer/counter flops to 0.
REQ-029 RST_N deassertion mid-measurement shall not resume it; a new START is required.
REQ-030 Release is assumed synchronous to CLK upstream; no internal reset synchronizer.

Verification
REQ-031 SIG period 16 cycles, high 8, START once -> VALID single pulse, PCNT=16, HCNT=8, BUSY low after VALID.
REQ-032 SIG period 10, high 3 -> PCNT=10, HCNT=3; second START on the next cycle -> next VALID with identical values.
REQ-033 SIG held low, CTRL=0, START -> TMO=1 and BUSY=0 after 65535 cycles, no VALID, PCNT/HCNT retain previous values.
REQ-034 START during HIGH, and CTRL changed from 0 to 15 mid-measurement -> both ignored; result and timeout behave per the original CTRL.
REQ-035 RST_N pulsed low during LOW -> all outputs 0 immediately; no VALID afterwards until a new START completes.
REQ-036 SIG driven asynchronously (random phase) with period 1000 cycles -> PCNT within 1000+/-1 across 100 runs.
